mio_responder: RTL and testbench
================================

MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait states inserted before acknowledge (legal range 0..15).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 CPU_MIO  input  1  CPU memory/IO request strobe.
REQ-005 WR  input  1  1 = write, 0 = read; qualified by CPU_MIO.
REQ-006 addr  input  32  byte address of request.
REQ-007 Data_out  input  32  CPU write data.
REQ-008 Data_in  output  32  read data returned to CPU.
REQ-009 MIO_ready  output  1  one-cycle transfer-complete acknowledge.
REQ-010 bus_err  output  1  error flag, valid only while MIO_ready=1.
REQ-011 led  output  16  LED peripheral register contents.

Function
REQ-012 Address map on addr[31:28]: 4'h0 = RAM, 256 words, index addr[9:2]; 4'hE = LED register (RW, bits [15:0], upper read bits 0); 4'hF = cycle counter (RO); all others unmapped.
REQ-013 FSM states IDLE, WAIT, ACK; reset state IDLE.
REQ-014 IDLE: when CPU_MIO=1 at a rising edge, latch addr, WR, Data_out; go to WAIT if WAIT_CYCLES>0, else ACK; CPU_MIO=0 stays IDLE.
REQ-015 WAIT: 4-bit down-counter loaded with WAIT_CYCLES-1 on entry; decrement each cycle; go to ACK at the edge where count is 0.
REQ-016 ACK: MIO_ready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-017 Latency: MIO_ready high during the (WAIT_CYCLES+1)th cycle after the sampling edge; WAIT_CYCLES=0 gives ack in the cycle immediately after sampling.
REQ-018 Inputs are ignored outside IDLE; changes to addr/WR/Data_out/CPU_MIO during WAIT/ACK do not affect the transfer in flight.
REQ-019 A CPU_MIO held high across ACK is resampled in IDLE as a new request; back-to-back transfers have at least one IDLE cycle between acks.
REQ-020 Read: Data_in holds selected data (RAM word, {16'b0,led}, or counter value) while MIO_ready=1; Data_in = 0 in all other cycles.
REQ-021 Write: committed at the rising edge ending the ACK cycle, using latched address and data; writes to counter region are ignored.
REQ-022 bus_err=1 during ACK if latched addr[1:0]!=0 or region is unmapped or request is a write to region 4'hF; erroneous requests perform no write and return Data_in = 0.
REQ-023 Counter: 32-bit, increments every cycle, wraps 32'hFFFF_FFFF -> 0; read returns value latched at the IDLE sampling edge.
REQ-024 RAM is single-port, word-wide, not initialised, not cleared by reset.
REQ-025 MIO_ready and bus_err are registered (driven from state), never combinational from inputs.

Reset
REQ-026 Reset asynchronously forces: state IDLE, MIO_ready=0, bus_err=0, Data_in=0, led=16'h0000, counter=0, wait counter=0, latched request cleared.
REQ-027 Reset asserted during WAIT or ACK aborts the transfer: no write committed, no acknowledge issued after release.
REQ-028 After reset release, the first request is sampled no earlier than the first rising edge with reset low.

Verification
REQ-029 WAIT_CYCLES=2; write 32'hDEADBEEF to addr 32'h0000_0010, then read it back -> each ack 3 cycles after sampling, read Data_in=32'hDEADBEEF, bus_err=0.
REQ-030 Write 32'h0001_A5A5 to 32'hE000_0000 -> led=16'hA5A5 after ACK edge; readback Data_in=32'h0000_A5A5.
REQ-031 Read 32'h0000_0002 (misaligned) and 32'h5000_0000 (unmapped) -> MIO_ready with bus_err=1, Data_in=0; write to 32'hF000_0000 -> bus_err=1, counter unaffected.
REQ-032 WAIT_CYCLES=0, CPU_MIO held high for 6 cycles -> MIO_ready pattern 0,1,0,1,0,1 (ack every second cycle).
REQ-033 Start write to 32'h0000_0020, assert reset in WAIT -> no ack; after release, read 32'h0000_0020 returns prior contents, led=0.
REQ-034 Force counter to 32'hFFFF_FFFE, read 32'hF000_0000 on consecutive requests -> values wrap through 0 with monotonic modulo-2^32 increments.

Source files
------------

// File: rtl/mio_responder.sv
// Memory/IO responder: a 256-word RAM, an LED register and a free-running cycle counter,
// each reached through a request/acknowledge handshake with a configurable number of wait states.
module mio_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] CNT_INIT    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        WR,
  input  logic [31:0] addr,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        bus_err,
  output logic [15:0] led
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_LED = 4'hE;
  localparam logic [3:0] REGION_CNT = 4'hF;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic        wr_q;
  logic [3:0]  region_q;
  logic [7:0]  idx_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt_snap_q;
  logic        err_q;
  logic        ready_q;
  logic        bus_err_q;
  logic [15:0] led_q;
  logic [31:0] cnt_q;

  logic        err_d;
  logic [31:0] rd_data_d;
  logic        ram_we;

  logic [31:0] mem [256];

  // Only the region nibble and the word index decode; the middle address bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[27:10];

  function automatic logic req_err(input logic [31:0] a, input logic w);
    logic mapped;
    mapped = (a[31:28] == REGION_RAM) || (a[31:28] == REGION_LED) || (a[31:28] == REGION_CNT);
    return (a[1:0] != 2'b00) || !mapped || (w && (a[31:28] == REGION_CNT));
  endfunction

  assign err_d = req_err(addr, WR);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 4'd0;
      wr_q       <= 1'b0;
      region_q   <= 4'd0;
      idx_q      <= 8'd0;
      wdata_q    <= 32'd0;
      cnt_snap_q <= 32'd0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      led_q      <= 16'h0000;
      cnt_q      <= CNT_INIT;
    end else begin
      cnt_q     <= cnt_q + 32'd1;
      ready_q   <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CPU_MIO) begin
            wr_q       <= WR;
            region_q   <= addr[31:28];
            idx_q      <= addr[9:2];
            wdata_q    <= Data_out;
            cnt_snap_q <= cnt_q;
            err_q      <= err_d;
            if (WAIT_CYCLES == 0) begin
              state_q   <= S_ACK;
              ready_q   <= 1'b1;
              bus_err_q <= err_d;
            end else begin
              state_q <= S_WAIT;
              wcnt_q  <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q   <= S_ACK;
            ready_q   <= 1'b1;
            bus_err_q <= err_q;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_ACK: begin
          // The write lands on the edge that closes the acknowledge cycle.
          state_q <= S_IDLE;
          if (wr_q && !err_q && (region_q == REGION_LED)) begin
            led_q <= wdata_q[15:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_we = (state_q == S_ACK) && wr_q && !err_q && (region_q == REGION_RAM);

  // NOTE: the RAM array has no reset; clearing a memory costs a write port per word and its contents are undefined by design.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // NOTE: rd_data_d gets a default first so no path through this block can infer a latch.
  always_comb begin
    rd_data_d = 32'd0;
    if ((state_q == S_ACK) && !wr_q && !err_q) begin
      case (region_q)
        REGION_RAM: rd_data_d = mem[idx_q];
        REGION_LED: rd_data_d = {16'h0000, led_q};
        REGION_CNT: rd_data_d = cnt_snap_q;
        default:    rd_data_d = 32'd0;
      endcase
    end
  end

  assign Data_in   = rd_data_d;
  assign MIO_ready = ready_q;
  assign bus_err   = bus_err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench: drivers queue the expected acknowledge, and per-DUT monitors check each one.
// dut_a runs with two wait states; dut_b runs with zero wait states and its counter near wrap.
module tb_mio_responder;

  localparam int WAIT_A = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, cpu_a, wr_a;
  logic [31:0] addr_a, dout_a, din_a;
  logic        rdy_a, err_a;
  logic [15:0] led_a;
  logic        rst_b, cpu_b, wr_b;
  logic [31:0] addr_b, dout_b, din_b;
  logic        rdy_b, err_b;
  logic [15:0] led_b;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] cnt_model_a;
  exp_t        q_a[$];
  exp_t        q_b[$];

  mio_responder #(.WAIT_CYCLES(WAIT_A), .CNT_INIT(32'h0000_0000)) dut_a (
    .clk(clk), .reset(rst_a), .CPU_MIO(cpu_a), .WR(wr_a), .addr(addr_a), .Data_out(dout_a),
    .Data_in(din_a), .MIO_ready(rdy_a), .bus_err(err_a), .led(led_a));

  mio_responder #(.WAIT_CYCLES(0), .CNT_INIT(32'hFFFF_FFFE)) dut_b (
    .clk(clk), .reset(rst_b), .CPU_MIO(cpu_b), .WR(wr_b), .addr(addr_b), .Data_out(dout_b),
    .Data_in(din_b), .MIO_ready(rdy_b), .bus_err(err_b), .led(led_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference count of dut_a's cycle counter.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) cnt_model_a <= 32'd0;
    else       cnt_model_a <= cnt_model_a + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdy_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_ack", {31'd0, rdy_a}, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", din_a, e.data);
        check("a_bus_err", {31'd0, err_a}, {31'd0, e.err});
        check("a_ack_cycle", cyc, e.cyc);
      end
    end else begin
      check("a_idle_data", din_a, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (rdy_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_ack", {31'd0, rdy_b}, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", din_b, e.data);
        check("b_bus_err", {31'd0, err_b}, {31'd0, e.err});
        check("b_ack_cycle", cyc, e.cyc);
      end
    end else begin
      check("b_idle_data", din_b, 32'd0);
    end
  end

  task automatic drain_a();
    int n = 0;
    while (q_a.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("a_ack_timeout", 32'(q_a.size()), 32'd0);
    @(negedge clk);
  endtask

  // Issue one request; after the sampling edge the inputs are scrambled to show they are ignored.
  task automatic issue_a(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e, input bit use_cnt);
    exp_t e;
    @(negedge clk);
    cpu_a  = 1'b1;
    wr_a   = wr;
    addr_a = a;
    dout_a = d;
    @(posedge clk);
    #1;
    e.data = use_cnt ? (cnt_model_a - 32'd1) : exp_d;
    e.err  = exp_e;
    e.cyc  = cyc + WAIT_A;
    q_a.push_back(e);
    cpu_a  = 1'b0;
    wr_a   = ~wr;
    addr_a = ~a;
    dout_a = ~d;
    drain_a();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   base;
    rst_a = 1'b1; cpu_a = 1'b0; wr_a = 1'b0; addr_a = '0; dout_a = '0;
    rst_b = 1'b1; cpu_b = 1'b0; wr_b = 1'b0; addr_b = '0; dout_b = '0;
    repeat (2) @(negedge clk);
    check("a_rst_ready", {31'd0, rdy_a}, 32'd0);
    check("a_rst_bus_err", {31'd0, err_a}, 32'd0);
    check("a_rst_led", {16'd0, led_a}, 32'd0);
    check("b_rst_led", {16'd0, led_b}, 32'd0);
    rst_a = 1'b0;

    issue_a(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    issue_a(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue_a(1'b0, 32'h0000_0410, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue_a(1'b1, 32'h0000_0011, 32'h0BAD_0BAD, 32'h0, 1'b1, 1'b0);
    issue_a(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue_a(1'b1, 32'hE000_0000, 32'h0001_A5A5, 32'h0, 1'b0, 1'b0);
    check("a_led_after_write", {16'd0, led_a}, 32'h0000_A5A5);
    issue_a(1'b0, 32'hE000_0000, 32'h0, 32'h0000_A5A5, 1'b0, 1'b0);
    issue_a(1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1, 1'b0);
    issue_a(1'b0, 32'h5000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
    issue_a(1'b1, 32'hF000_0000, 32'h0000_1234, 32'h0, 1'b1, 1'b0);
    issue_a(1'b0, 32'hF000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    issue_a(1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0, 1'b0);

    // Abort a write while it sits in the wait states.
    @(negedge clk);
    cpu_a = 1'b1; wr_a = 1'b1; addr_a = 32'h0000_0020; dout_a = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    cpu_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (6) @(negedge clk);
    check("a_led_after_abort", {16'd0, led_a}, 32'h0);
    issue_a(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // Zero wait states, request held high: acks alternate and counter reads cross the wrap.
    @(negedge clk);
    rst_b = 1'b0; cpu_b = 1'b1; wr_b = 1'b0; addr_b = 32'hF000_0000;
    base = cyc;
    e.err = 1'b0;
    e.data = 32'hFFFF_FFFE; e.cyc = base + 1; q_b.push_back(e);
    e.data = 32'h0000_0000; e.cyc = base + 3; q_b.push_back(e);
    e.data = 32'h0000_0002; e.cyc = base + 5; q_b.push_back(e);
    check("b_ready_c0", {31'd0, rdy_b}, 32'd0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b_ready_c%0d", i), {31'd0, rdy_b}, 32'(i % 2));
    end
    cpu_b = 1'b0;
    repeat (4) @(negedge clk);

    check("a_queue_empty", 32'(q_a.size()), 32'd0);
    check("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
